imem_prog_ctrl: RTL and testbench

Boot/programming controller that shares the instruction memory between CPU fetch and a byte-stream loader (UART/debug bridge).
- Idle: the CPU fetch address drives the memory read port, and no writes occur.
- Programming: the controller holds the CPU and parses a framed byte stream (base address, word count, data). It assembles little-endian words and issues full-word writes to the memory.
- Sits between the fetch stage, the loader front-end and the instruction memory.

---
 rtl/imem_prog_ctrl_pkg.sv | 22 ++
 rtl/imem_prog_ctrl_if.sv | 35 +++
 rtl/imem_prog_ctrl_byte_packer.sv | 40 ++++
 rtl/imem_prog_ctrl.sv | 169 ++++++++++++++++
 tb/tb_imem_prog_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_prog_ctrl_pkg.sv
// rtl/imem_prog_ctrl_pkg.sv - shared types and constants for the instruction-memory programming controller
package imem_prog_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } prog_state_t;

    // Header is base address (4 bytes LE) followed by word count (4 bytes LE)
    localparam int HDR_BYTES = 8;

    // Full-word byte enables for every programming write
    localparam logic [3:0] WE_WORD = 4'hF;

endpackage

// File: rtl/imem_prog_ctrl_if.sv
// rtl/imem_prog_ctrl_if.sv - loader byte stream and instruction-memory port bundle
interface imem_prog_ctrl_if;
    import imem_prog_ctrl_pkg::*;

    // Loader byte stream
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    // Instruction memory port
    logic [3:0] mem_we;
    addr_t      mem_addr;
    word_t      mem_wdata;

    // Controller side: consumes bytes, drives the memory
    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    // Environment side: byte source and memory
    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_prog_ctrl_byte_packer.sv
// rtl/imem_prog_ctrl_byte_packer.sv - little-endian byte-to-word assembler used for header fields and data words
module imem_prog_ctrl_byte_packer
    import imem_prog_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       accept,
    input  logic [7:0] data,
    output word_t      word,
    output word_t      word_next,
    output logic       word_valid
);

    logic [1:0] idx;

    // Accumulator with the incoming byte already merged into its lane, so the
    // caller can act on a complete word in the same cycle its last byte lands
    always_comb begin
        word_next = word;
        word_next[{idx, 3'b000} +: 8] = data;
    end

    assign word_valid = accept && (idx == 2'd3);

    // Byte lane index and accumulator; index wraps so consecutive words pack back-to-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (accept) begin
            word <= word_next;
            idx  <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_prog_ctrl.sv
// rtl/imem_prog_ctrl.sv - boot/programming controller sharing instruction memory between fetch and a byte loader
module imem_prog_ctrl
    import imem_prog_ctrl_pkg::*;
#(
    parameter int MEM_WORDS   = 2048,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_req,
    input  addr_t            cpu_pc,
    output logic             cpu_hold,
    output logic             prog_done,
    output logic             prog_err,
    imem_prog_ctrl_if.master bus
);

    localparam int          TW        = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYC - 1);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_WORDS);
    localparam logic [2:0]  BASE_LAST = 3'(HDR_BYTES / 2 - 1);
    localparam logic [2:0]  HDR_LAST  = 3'(HDR_BYTES - 1);

    prog_state_t   state;
    word_t         base;
    addr_t         cur_addr;
    word_t         remaining;
    logic [2:0]    hdr_cnt;
    logic [TW-1:0] tcnt;

    logic          accept;
    logic          pk_clear;
    word_t         pk_word;
    word_t         pk_word_next;
    logic          pk_word_valid;
    logic [32:0]   hdr_end;

    assign accept   = bus.s_valid && bus.s_ready;
    assign pk_clear = (state == ST_IDLE);

    // One past the last word index the session would touch, without wrap
    assign hdr_end = {3'b000, base[31:2]} + {1'b0, pk_word_next};

    imem_prog_ctrl_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .accept     (accept),
        .data       (bus.s_data),
        .word       (pk_word),
        .word_next  (pk_word_next),
        .word_valid (pk_word_valid)
    );

    // Status and handshake decoded straight from the state register
    always_comb begin
        bus.s_ready   = (state == ST_HDR) || (state == ST_DATA);
        cpu_hold      = (state != ST_IDLE);
        bus.mem_we    = (state == ST_WRITE) ? WE_WORD : 4'h0;
        bus.mem_wdata = pk_word;
        prog_done     = (state == ST_DONE);
        prog_err      = (state == ST_ERR);
    end

    // Memory address mux: fetch in idle, partial/complete base in header, write pointer otherwise
    always_comb begin
        case (state)
            ST_IDLE: bus.mem_addr = cpu_pc;
            ST_HDR:  bus.mem_addr = (hdr_cnt <= BASE_LAST) ? pk_word : base;
            default: bus.mem_addr = cur_addr;
        endcase
    end

    // Session FSM with header parsing, write pointer and inter-byte timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            base      <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            hdr_cnt   <= '0;
            tcnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    base    <= '0;
                    hdr_cnt <= '0;
                    tcnt    <= '0;
                    if (prog_req) begin
                        state <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (!prog_req) begin
                        state <= ST_ERR;
                    end else if (accept) begin
                        tcnt    <= '0;
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt == BASE_LAST) begin
                            base <= pk_word_next;
                        end
                        if (hdr_cnt == HDR_LAST) begin
                            cur_addr  <= base;
                            remaining <= pk_word_next;
                            if (base[1:0] != 2'b00) begin
                                state <= ST_ERR;
                            end else if (hdr_end > MEM_LIMIT) begin
                                state <= ST_ERR;
                            end else if (pk_word_next == '0) begin
                                state <= ST_DONE;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end else if (tcnt == TLIM) begin
                        state <= ST_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (!prog_req) begin
                        state <= ST_ERR;
                    end else if (accept) begin
                        tcnt <= '0;
                        if (pk_word_valid) begin
                            state <= ST_WRITE;
                        end
                    end else if (tcnt == TLIM) begin
                        state <= ST_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                // The write itself happens during this cycle; an abort only
                // redirects where we go afterwards
                ST_WRITE: begin
                    cur_addr  <= cur_addr + 32'd4;
                    remaining <= remaining - 32'd1;
                    if (!prog_req) begin
                        state <= ST_ERR;
                    end else if (remaining == 32'd1) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DATA;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                ST_ERR: begin
                    if (!prog_req) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// tb/tb_imem_prog_ctrl.sv - self-checking bench for imem_prog_ctrl
module tb_imem_prog_ctrl;

    localparam int MEM_W = 2048;
    localparam int TO_C  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_req;
    logic [31:0] cpu_pc;
    logic        cpu_hold;
    logic        prog_done;
    logic        prog_err;

    imem_prog_ctrl_if bus();

    imem_prog_ctrl #(.MEM_WORDS(MEM_W), .TIMEOUT_CYC(TO_C)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_req  (prog_req),
        .cpu_pc    (cpu_pc),
        .cpu_hold  (cpu_hold),
        .prog_done (prog_done),
        .prog_err  (prog_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] obs_q[$];
    int          done_cnt = 0;
    logic [31:0] wbuf[16];
    logic [63:0] exp_q[$];

    // Observed memory writes and done pulses
    always @(negedge clk) begin
        if (bus.mem_we != 4'h0) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
        if (prog_done) done_cnt = done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge
    task automatic send_byte(input logic [7:0] b);
        int t;
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        t = 0;
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("s_ready_wait", 64'(t), 64'(0));
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic compare_writes(input int obs_base, input int done_base, input int exp_done);
        check("wr_count", 64'(obs_q.size() - obs_base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_base + i < obs_q.size()) check("wr_entry", obs_q[obs_base + i], exp_q[i]);
        end
        check("done_count", 64'(done_cnt - done_base), 64'(exp_done));
    endtask

    // One full session; expected outcome comes from the header rules and the words in wbuf
    task automatic do_load(input logic [31:0] base, input int cnt);
        bit     exp_err;
        longint endw;
        int     ob;
        int     db;
        ob = obs_q.size();
        db = done_cnt;
        exp_q.delete();
        endw    = longint'(base / 4) + longint'(cnt);
        exp_err = ((base % 4) != 0) || (endw > longint'(MEM_W));
        if (!exp_err) begin
            for (int i = 0; i < cnt; i++) exp_q.push_back({base + 32'(4 * i), wbuf[i]});
        end
        prog_req = 1'b1;
        @(negedge clk);
        check("hdr_hold", 64'(cpu_hold), 64'(1));
        send_word(base);
        send_word(32'(cnt));
        if (exp_err) begin
            check("err_flag", 64'(prog_err), 64'(1));
            repeat (3) @(negedge clk);
            check("err_sticky", 64'({prog_err, cpu_hold}), 64'(3));
            prog_req = 1'b0;
            @(negedge clk);
            check("err_exit", 64'({prog_err, cpu_hold}), 64'(0));
        end else begin
            for (int i = 0; i < cnt; i++) begin
                send_word(wbuf[i]);
                check("wr_we", 64'(bus.mem_we), 64'(4'hF));
                check("wr_addr", 64'(bus.mem_addr), 64'(base + 32'(4 * i)));
                check("wr_data", 64'(bus.mem_wdata), 64'(wbuf[i]));
                check("wr_sready", 64'(bus.s_ready), 64'(0));
                if (i == cnt - 1) @(negedge clk);
            end
            check("done_pulse", 64'({prog_done, cpu_hold, bus.mem_we}), 64'({1'b1, 1'b1, 4'h0}));
            prog_req = 1'b0;
            @(negedge clk);
            check("done_fall", 64'({prog_done, cpu_hold}), 64'(0));
            check("idle_addr", 64'(bus.mem_addr), 64'(cpu_pc));
        end
        @(negedge clk);
        compare_writes(ob, db, exp_err ? 0 : 1);
    endtask

    initial begin
        int          k;
        int          ob;
        int          cnt;
        logic [31:0] b;

        rst         = 1'b1;
        prog_req    = 1'b0;
        cpu_pc      = 32'h0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h0;
        repeat (2) @(negedge clk);
        check("rst_outs", 64'({bus.s_ready, cpu_hold, bus.mem_we, prog_done, prog_err}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Idle passthrough
        cpu_pc = 32'h0000_0104;
        #1;
        check("idle_addr104", 64'(bus.mem_addr), 64'(32'h104));
        check("idle_outs", 64'({bus.s_ready, cpu_hold, bus.mem_we}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_pc = $urandom;
            #1;
            check("idle_addr_rand", 64'(bus.mem_addr), 64'(cpu_pc));
        end
        @(negedge clk);

        // Directed normal load
        wbuf[0] = 32'h1234_5678;
        wbuf[1] = 32'hDEAD_BEEF;
        do_load(32'h0000_0010, 2);

        // Header errors: misaligned base, range overflow
        do_load(32'h0000_0002, 1);
        do_load(32'h0000_1FFC, 2);

        // Exactly reaching the end of memory is legal
        wbuf[0] = $urandom;
        wbuf[1] = $urandom;
        do_load(32'h0000_1FF8, 2);

        // Zero-length session
        do_load(32'h0000_0100, 0);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            cnt = int'($urandom_range(1, 4));
            for (int i = 0; i < cnt; i++) wbuf[i] = $urandom;
            b = 32'($urandom_range(0, MEM_W - cnt)) * 32'd4;
            if (s == 4) b = b | 32'($urandom_range(1, 3));
            if (s == 5) b = 32'($urandom_range(MEM_W - cnt + 1, MEM_W)) * 32'd4;
            do_load(b, cnt);
        end

        // Timeout mid-word
        ob = obs_q.size();
        prog_req = 1'b1;
        @(negedge clk);
        send_word(32'h40);
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        k = 0;
        while (!prog_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", 64'(k), 64'(TO_C));
        prog_req = 1'b0;
        @(negedge clk);
        check("timeout_exit", 64'({prog_err, cpu_hold}), 64'(0));
        check("timeout_nowr", 64'(obs_q.size() - ob), 64'(0));

        // prog_req dropped in DATA
        ob = obs_q.size();
        prog_req = 1'b1;
        @(negedge clk);
        send_word(32'h20);
        send_word(32'd2);
        send_byte(8'h11);
        prog_req = 1'b0;
        @(negedge clk);
        check("abort_err", 64'(prog_err), 64'(1));
        @(negedge clk);
        check("abort_exit", 64'({prog_err, cpu_hold}), 64'(0));
        check("abort_nowr", 64'(obs_q.size() - ob), 64'(0));

        // Async reset during DATA, then a clean session
        prog_req = 1'b1;
        @(negedge clk);
        send_word(32'h80);
        send_word(32'd1);
        send_byte(8'h55);
        send_byte(8'h66);
        #2;
        rst = 1'b1;
        #1;
        check("arst_outs", 64'({bus.s_ready, cpu_hold, bus.mem_we, prog_done, prog_err}), 64'(0));
        prog_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wbuf[0] = $urandom;
        do_load(32'h0000_0080, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
